// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: FSM state encodings, write-back selects and instruction classes.
package multicycle_controller_pkg;
    localparam int ILEN = 32;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_RETIRE = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DMEM = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;
    typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_SW, OP_LW, OP_ADDI, OP_LUI, OP_JAL} op_e;
    // Decoder one-hots are meant to be exclusive; resolve overlaps by fixed priority.
    function automatic op_e decode_op(input logic add, sub, sw, lw, addi, lui, jal);
        return jal ? OP_JAL : lui ? OP_LUI : lw ? OP_LW : sw ? OP_SW :
               addi ? OP_ADDI : sub ? OP_SUB : add ? OP_ADD : OP_NONE;
    endfunction
    function automatic logic [1:0] wb_of(input op_e op);
        return op == OP_LW ? WB_DMEM : op == OP_JAL ? WB_PC4 : op == OP_LUI ? WB_IMM : WB_ALU;
    endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction- and data-memory handshakes between controller and memories.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;
    logic            imem_req;
    logic            imem_ready;
    logic [ILEN-1:0] imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;
    modport master(output imem_req, dmem_req, dmem_we, input imem_ready, imem_rdata, dmem_ready);
    modport slave(input imem_req, dmem_req, dmem_we, output imem_ready, imem_rdata, dmem_ready);
endinterface

// File: rtl/multicycle_controller_pc_unit.sv
// multicycle_controller_pc_unit: PC register; advances by 4, or by the JAL offset, on retire.
module multicycle_controller_pc_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic            jal,
    input  logic [31:0]     imm,
    output logic [XLEN-1:0] pc
);
    logic            unused_imm;
    logic [XLEN-1:0] offset;
    assign unused_imm = &{1'b0, imm[31:20]};
    // JAL immediate is a halfword offset: sign-extend the 20-bit field and shift left by one.
    assign offset = {{11{imm[19]}}, imm[19:0], 1'b0};
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (adv)
            pc <= pc + (jal ? offset : XLEN'(4));
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/RETIRE sequencer owning IR and PC, emitting per-cycle datapath strobes.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    multicycle_controller_if.master bus,
    output logic [ILEN-1:0]        ir,
    input  logic                   ins_ADD,
    input  logic                   ins_SUB,
    input  logic                   ins_SW,
    input  logic                   ins_LW,
    input  logic                   ins_ADDI,
    input  logic                   ins_LUI,
    input  logic                   ins_JAL,
    input  logic [31:0]            IM,
    input  logic [1:0]             cnt_set,
    output logic [XLEN-1:0]        pc,
    output logic [1:0]             step,
    output logic                   alu_sub,
    output logic                   alu_b_imm,
    output logic                   reg_we,
    output logic [1:0]             wb_sel,
    output logic                   busy,
    output logic                   retire,
    output logic                   illegal
);
    logic [2:0] state;
    logic [1:0] step_max;
    op_e        op;
    op_e        dec_op;
    logic       mem_op;
    logic       last_step;
    logic       op_phase;

    assign dec_op         = decode_op(ins_ADD, ins_SUB, ins_SW, ins_LW, ins_ADDI, ins_LUI, ins_JAL);
    assign mem_op         = op == OP_LW || op == OP_SW;
    assign last_step      = state == ST_EXEC && step == step_max;
    assign op_phase       = state == ST_EXEC || state == ST_RETIRE;
    assign bus.imem_req   = state == ST_FETCH;
    assign bus.dmem_req   = last_step && mem_op;
    assign bus.dmem_we    = bus.dmem_req && op == OP_SW;
    assign alu_sub        = op_phase && op == OP_SUB;
    assign alu_b_imm      = op_phase && (op == OP_ADDI || op == OP_LW || op == OP_SW);
    assign retire         = state == ST_RETIRE;
    assign reg_we         = retire && op != OP_SW;
    assign wb_sel         = retire ? wb_of(op) : WB_ALU;
    assign busy           = state != ST_IDLE && state != ST_TRAP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ir       <= '0;
            op       <= OP_NONE;
            step     <= '0;
            step_max <= '0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:   if (run) state <= ST_FETCH;
                ST_FETCH:  if (bus.imem_ready) begin
                    ir    <= bus.imem_rdata;
                    state <= ST_DECODE;
                end
                ST_DECODE: if (dec_op == OP_NONE) begin
                    illegal <= 1'b1;
                    state   <= ST_TRAP;
                end else begin
                    op       <= dec_op;
                    step_max <= cnt_set;
                    step     <= '0;
                    state    <= ST_EXEC;
                end
                // Memory ops park on the last step until the data access completes.
                ST_EXEC:   if (step != step_max)
                    step <= step + 2'd1;
                else if (!mem_op || bus.dmem_ready) begin
                    step  <= '0;
                    state <= ST_RETIRE;
                end
                ST_RETIRE: state <= run ? ST_FETCH : ST_IDLE;
                default:   state <= state;
            endcase
        end
    end

    multicycle_controller_pc_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .adv (retire),
        .jal (op == OP_JAL),
        .imm (IM),
        .pc  (pc)
    );
endmodule
